// File: rtl/alu_writeback_arbiter.sv
// Collects ALU result beats into per-unit FIFOs and drains them round-robin onto the
// single register-file write port, flagging beats dropped on a full FIFO.
module alu_wb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr, r_rd;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_full, w_push_ok;

    // Extra MSB on the pointers distinguishes full from empty when the indices match.
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty   = (r_wr == r_rd);
    assign w_push_ok = i_push && (!w_full || i_pop);
    assign o_drop    = i_push && w_full && !i_pop;
    assign o_rdata   = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (i_pop)     r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_wdata;
    end
endmodule

module alu_writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int N_UNITS        = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_UNITS-1:0]                 in_valid,
    input  logic [N_UNITS*DATA_WIDTH-1:0]      in_data,
    input  logic [N_UNITS*REG_ADDR_WIDTH-1:0]  in_user,
    output logic                               wb_valid,
    output logic [DATA_WIDTH-1:0]              wb_data,
    output logic [REG_ADDR_WIDTH-1:0]          wb_address,
    input  logic                               wb_ready,
    output logic [N_UNITS-1:0]                 overflow,
    input  logic                               clear_overflow,
    output logic                               busy
);
    localparam int EW = DATA_WIDTH + REG_ADDR_WIDTH;
    localparam int PW = $clog2(N_UNITS);

    logic [N_UNITS-1:0]         w_empty, w_pop, w_drop;
    logic [N_UNITS-1:0][EW-1:0] w_head;
    logic [EW-1:0]              w_sel;
    logic [PW-1:0]              w_grant;
    logic                       w_found, w_load;

    logic [PW-1:0]              r_rr_ptr;
    logic                       r_wb_valid;
    logic [DATA_WIDTH-1:0]      r_wb_data;
    logic [REG_ADDR_WIDTH-1:0]  r_wb_address;
    logic [N_UNITS-1:0]         r_overflow;

    for (genvar g = 0; g < N_UNITS; g++) begin : g_unit
        alu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .i_push  (in_valid[g]),
            .i_pop   (w_pop[g]),
            .i_wdata ({in_user[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                       in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .o_rdata (w_head[g]),
            .o_empty (w_empty[g]),
            .o_drop  (w_drop[g])
        );
    end

    // First non-empty FIFO scanning upward from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!w_found && !w_empty[(int'(r_rr_ptr) + k) % N_UNITS]) begin
                w_found = 1'b1;
                w_grant = PW'((int'(r_rr_ptr) + k) % N_UNITS);
            end
        end
    end

    assign w_load = !r_wb_valid || wb_ready;
    assign w_sel  = w_head[w_grant];

    always_comb begin
        w_pop = '0;
        if (w_load && w_found) w_pop[w_grant] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_address <= '0;
            r_overflow   <= '0;
        end else begin
            if (w_load) begin
                r_wb_valid <= w_found;
                if (w_found) begin
                    r_wb_data    <= w_sel[DATA_WIDTH-1:0];
                    r_wb_address <= w_sel[EW-1:DATA_WIDTH];
                    r_rr_ptr     <= (int'(w_grant) == N_UNITS - 1) ? '0 : w_grant + 1'b1;
                end
            end
            // A drop in the same cycle as a clear leaves the bit set.
            r_overflow <= (clear_overflow ? '0 : r_overflow) | w_drop;
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_address = r_wb_address;
    assign overflow   = r_overflow;
    assign busy       = r_wb_valid || !(&w_empty);
endmodule

// File: tb/tb_alu_writeback_arbiter.sv
// Bench for alu_writeback_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_alu_writeback_arbiter;
    localparam int N = 4, DW = 32, AW = 4, DEPTH = 4;

    logic           clock, reset;
    logic [N-1:0]   in_valid;
    logic [N*DW-1:0] in_data;
    logic [N*AW-1:0] in_user;
    logic           wb_valid, wb_ready, clear_overflow, busy;
    logic [DW-1:0]  wb_data;
    logic [AW-1:0]  wb_address;
    logic [N-1:0]   overflow;

    alu_writeback_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .N_UNITS(N), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_user(in_user),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_address(wb_address), .wb_ready(wb_ready),
        .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0, checks = 0, nwrites = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: one queue per unit, an output slot and a round-robin pointer.
    logic [AW+DW-1:0] mq [N][$];
    logic             m_v;
    logic [DW-1:0]    m_d;
    logic [AW-1:0]    m_a;
    logic [N-1:0]     m_ovf;
    int               m_p;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_v = 1'b0; m_d = '0; m_a = '0; m_ovf = '0; m_p = 0;
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                              input logic [N*AW-1:0] u, input logic r, input logic c);
        int g;
        logic [AW+DW-1:0] e;
        g = -1;
        if (!m_v || r) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(m_p + k) % N].size() > 0) g = (m_p + k) % N;
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_v = 1'b1; m_d = e[DW-1:0]; m_a = e[AW+DW-1:DW];
                m_p = (g + 1) % N;
            end else m_v = 1'b0;
        end
        if (c) m_ovf = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({u[i*AW +: AW], d[i*DW +: DW]});
                else m_ovf[i] = 1'b1;
            end
    endtask

    function automatic logic m_busy();
        logic b;
        b = m_v;
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic [N*AW-1:0] u, input logic r, input logic c);
        in_valid = v; in_data = d; in_user = u; wb_ready = r; clear_overflow = c;
        if (wb_valid && r) nwrites++;
        @(posedge clock);
        model_step(v, d, u, r, c);
        #1;
        chk("m_valid", 128'(wb_valid), 128'(m_v));
        if (m_v) begin
            chk("m_data", 128'(wb_data), 128'(m_d));
            chk("m_addr", 128'(wb_address), 128'(m_a));
        end
        chk("m_ovf", 128'(overflow), 128'(m_ovf));
        chk("m_busy", 128'(busy), 128'(m_busy()));
    endtask

    task automatic idle(input logic r, input logic c);
        cyc('0, '0, '0, r, c);
    endtask

    task automatic do_reset();
        in_valid = '0; in_data = '0; in_user = '0; wb_ready = 1'b0; clear_overflow = 1'b0;
        reset = 1'b0;
        #4;
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [N*DW-1:0] one_d(input int i, input logic [DW-1:0] d);
        logic [N*DW-1:0] x;
        x = '0; x[i*DW +: DW] = d;
        return x;
    endfunction

    function automatic logic [N*AW-1:0] one_u(input int i, input logic [AW-1:0] a);
        logic [N*AW-1:0] x;
        x = '0; x[i*AW +: AW] = a;
        return x;
    endfunction

    typedef struct {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic [N*AW-1:0] u;
        logic            r, c;
        logic            ev;
        logic [DW-1:0]   ed;
        logic [AW-1:0]   ea;
        logic [N-1:0]    eo;
        logic            eb;
    } vec_t;

    vec_t tbl[$];
    localparam logic [N*DW-1:0] BD = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [N*AW-1:0] BU = 16'h3210;

    task automatic add(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N*AW-1:0] u,
                       input logic ev, input logic [DW-1:0] ed, input logic [AW-1:0] ea, input logic eb);
        tbl.push_back('{v, d, u, 1'b1, 1'b0, ev, ed, ea, '0, eb});
    endtask

    // All four units push once; writes come out starting at unit 'first'.
    task automatic burst_rows(input int first);
        int un;
        add(4'hF, BD, BU, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < N; k++) begin
            un = (first + k) % N;
            add('0, '0, '0, 1'b1, 32'hA0 + DW'(un), AW'(un), 1'b1);
        end
        add('0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int n0;
        vec_t t;
        in_valid = '0; in_data = '0; in_user = '0; wb_ready = 1'b0; clear_overflow = 1'b0;
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 128'(wb_valid), 128'd0);
        chk("rst_data", 128'(wb_data), 128'd0);
        chk("rst_addr", 128'(wb_address), 128'd0);
        chk("rst_ovf", 128'(overflow), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        reset = 1'b1;

        burst_rows(0);
        burst_rows(0);
        add(4'h8, BD, BU, 1'b0, '0, '0, 1'b1);
        add('0, '0, '0, 1'b1, 32'hA3, 4'd3, 1'b1);
        add('0, '0, '0, 1'b0, '0, '0, 1'b0);
        burst_rows(0);
        add(4'h4, one_d(2, 32'h3F800000), one_u(2, 4'd5), 1'b0, '0, '0, 1'b1);
        add('0, '0, '0, 1'b1, 32'h3F800000, 4'd5, 1'b1);
        add('0, '0, '0, 1'b0, '0, '0, 1'b0);
        burst_rows(3);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            in_valid = t.v; in_data = t.d; in_user = t.u; wb_ready = t.r; clear_overflow = t.c;
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_valid", i), 128'(wb_valid), 128'(t.ev));
            if (t.ev) begin
                chk($sformatf("tbl%0d_data", i), 128'(wb_data), 128'(t.ed));
                chk($sformatf("tbl%0d_addr", i), 128'(wb_address), 128'(t.ea));
            end
            chk($sformatf("tbl%0d_ovf", i), 128'(overflow), 128'(t.eo));
            chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(t.eb));
        end

        // Backpressure: five beats from unit 0 while the write port is stalled.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(4'h1, one_d(0, 32'hB000 + DW'(k)), one_u(0, AW'(k)), 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("bp_hold_valid", 128'(wb_valid), 128'd1);
        chk("bp_hold_data", 128'(wb_data), 128'h0000B000);
        chk("bp_no_ovf", 128'(overflow), 128'd0);
        n0 = nwrites;
        for (int k = 0; k < 7; k++) idle(1'b1, 1'b0);
        chk("bp_writes", 128'(nwrites - n0), 128'd5);
        chk("bp_idle", 128'(busy), 128'd0);

        // Overflow on unit 1, clear, then clear racing a drop.
        do_reset();
        for (int k = 0; k < DEPTH + 2; k++) begin
            cyc(4'h2, one_d(1, 32'hC000 + DW'(k)), one_u(1, AW'(k)), 1'b0, 1'b0);
            if (k == DEPTH) chk("ovf_before", 128'(overflow), 128'd0);
        end
        chk("ovf_set", 128'(overflow), 128'h2);
        idle(1'b0, 1'b1);
        chk("ovf_clear", 128'(overflow), 128'd0);
        cyc(4'h2, one_d(1, 32'hC100), one_u(1, 4'd9), 1'b0, 1'b1);
        chk("ovf_set_wins", 128'(overflow), 128'h2);
        idle(1'b0, 1'b1);

        // Push into the full FIFO in the cycle its head is popped.
        n0 = nwrites;
        cyc(4'h2, one_d(1, 32'hC200), one_u(1, 4'd10), 1'b1, 1'b0);
        chk("fullpop_no_ovf", 128'(overflow), 128'd0);
        for (int k = 0; k < 6; k++) idle(1'b1, 1'b0);
        chk("fullpop_writes", 128'(nwrites - n0), 128'd6);
        chk("fullpop_idle", 128'(busy), 128'd0);

        // Asynchronous reset between edges with three beats buffered.
        do_reset();
        cyc(4'h7, BD, BU, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 128'(wb_valid), 128'd0);
        chk("arst_data", 128'(wb_data), 128'd0);
        chk("arst_addr", 128'(wb_address), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        model_reset();
        #2 reset = 1'b1;
        n0 = nwrites;
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);
        chk("arst_no_stale", 128'(nwrites - n0), 128'd0);
        cyc(4'hF, BD, BU, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("arst_p0", 128'(wb_address), 128'd0);
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++)
            cyc(N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        for (int k = 0; k < 30; k++) idle(1'b1, 1'b0);
        chk("rand_drained", 128'(busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
